trap_ctrl: RTL

// - Sequencer for the CSR trap channel: on an accepted interrupt/exception it performs the machine-mode trap entry
//   (mepc, mcause, mtval, mstatus update, mtvec fetch) one CSR access per cycle; on mret it performs trap return.
// - Sits between the idex stage and the CSR file; stalls the pipeline (hold_o) while sequencing, then issues one jump.

---
 rtl/trap_ctrl_pkg.sv | 32 +++
 rtl/trap_ctrl_prio_enc.sv | 57 +++++
 rtl/trap_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants and types for the CSR trap sequencer.
//   - machine-mode CSR addresses touched during trap entry / return
//   - interrupt cause codes and mstatus bit positions
//   - sequencer state encoding
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [3:0] IRQ_CODE_EXT = 4'd11;
  localparam logic [3:0] IRQ_CODE_SFT = 4'd3;
  localparam logic [3:0] IRQ_CODE_TMR = 4'd7;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Entry runs S_EPC..S_JMP in order; return runs S_RSTAT -> S_RJMP.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EPC   = 3'd1,
    S_CAUSE = 3'd2,
    S_TVAL  = 3'd3,
    S_STAT  = 3'd4,
    S_JMP   = 3'd5,
    S_RSTAT = 3'd6,
    S_RJMP  = 3'd7
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// trap_ctrl_prio_enc: combinational trap request priority encoder.
//   Priority: exception > mret > external irq > software irq > timer irq.
//   Ports:
//     exc_valid / exc_cause  synchronous exception request and its code
//     mret                   trap return request
//     irq_en                 mstatus.MIE qualified with the instruction boundary
//     ext_irq/sft_irq/tmr_irq  interrupt levels
//     req_valid              some request wins this cycle
//     req_is_irq             winner is an interrupt
//     req_is_mret            winner is mret
//     req_code               cause code of the winner (0 for mret)
module trap_ctrl_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic       exc_valid,
  input  logic [3:0] exc_cause,
  input  logic       mret,
  input  logic       irq_en,
  input  logic       ext_irq,
  input  logic       sft_irq,
  input  logic       tmr_irq,
  output logic       req_valid,
  output logic       req_is_irq,
  output logic       req_is_mret,
  output logic [3:0] req_code
);

  // Fixed-priority selection of the single winning request.
  always_comb begin
    req_valid   = 1'b0;
    req_is_irq  = 1'b0;
    req_is_mret = 1'b0;
    req_code    = 4'd0;
    if (exc_valid) begin
      req_valid = 1'b1;
      req_code  = exc_cause;
    end else if (mret) begin
      req_valid   = 1'b1;
      req_is_mret = 1'b1;
    end else if (irq_en && ext_irq) begin
      req_valid  = 1'b1;
      req_is_irq = 1'b1;
      req_code   = IRQ_CODE_EXT;
    end else if (irq_en && sft_irq) begin
      req_valid  = 1'b1;
      req_is_irq = 1'b1;
      req_code   = IRQ_CODE_SFT;
    end else if (irq_en && tmr_irq) begin
      req_valid  = 1'b1;
      req_is_irq = 1'b1;
      req_code   = IRQ_CODE_TMR;
    end else begin
      req_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / return sequencer on the CSR trap channel.
//   Trap entry writes mepc, mcause, mtval, mstatus (one CSR per cycle) and then
//   reads mtvec and issues a single jump. mret rewrites mstatus and jumps to mepc.
//   The pipeline is held (hold_o) from the accept cycle through the jump cycle.
//   Build option: TRAP_VECTORED_EN enables vectored interrupt dispatch when
//   mtvec[1:0]==2'b01 (base + 4*code for interrupts, base for exceptions).
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     inst_valid_i, pc_i            instruction boundary strobe, trap pc
//     exc_valid_i/exc_cause_i/exc_tval_i  exception request
//     mret_i, mie_i                 trap return request, global irq enable
//     ext_irq_i/sft_irq_i/tmr_irq_i interrupt levels
//     trap_csr_*                    CSR port (rdata combinational on addr)
//     hold_o, jump_o, jump_addr_o   stall and redirect
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              exc_valid_i,
  input  logic [3:0]        exc_cause_i,
  input  logic [XLEN-1:0]   exc_tval_i,
  input  logic              mret_i,
  input  logic              mie_i,
  input  logic              ext_irq_i,
  input  logic              sft_irq_i,
  input  logic              tmr_irq_i,
  output logic              trap_csr_we_o,
  output logic [CSR_AW-1:0] trap_csr_addr_o,
  output logic [XLEN-1:0]   trap_csr_wdata_o,
  input  logic [XLEN-1:0]   trap_csr_rdata_i,
  output logic              hold_o,
  output logic              jump_o,
  output logic [XLEN-1:0]   jump_addr_o
);

  trap_state_e     state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, cause_r, tval_r;
  logic            req_valid_s, req_is_irq_s, req_is_mret_s, accept_s;
  logic [3:0]      req_code_s;
  logic [XLEN-1:0] stat_entry_s, stat_ret_s, jump_base_s, trap_target_s;

  trap_ctrl_prio_enc u_prio (
    .exc_valid   (exc_valid_i),
    .exc_cause   (exc_cause_i),
    .mret        (mret_i),
    .irq_en      (mie_i & inst_valid_i),
    .ext_irq     (ext_irq_i),
    .sft_irq     (sft_irq_i),
    .tmr_irq     (tmr_irq_i),
    .req_valid   (req_valid_s),
    .req_is_irq  (req_is_irq_s),
    .req_is_mret (req_is_mret_s),
    .req_code    (req_code_s)
  );

  // Requests are only taken in IDLE; non-IDLE arrivals are dropped, not queued.
  assign accept_s = (state_r == S_IDLE) & req_valid_s & ~rst;
  assign hold_o   = accept_s | (state_r != S_IDLE);

  // mstatus read-modify-write values; all other bits pass through.
  always_comb begin
    stat_entry_s                   = trap_csr_rdata_i;
    stat_entry_s[MSTATUS_MPIE_BIT] = trap_csr_rdata_i[MSTATUS_MIE_BIT];
    stat_entry_s[MSTATUS_MIE_BIT]  = 1'b0;
    stat_ret_s                     = trap_csr_rdata_i;
    stat_ret_s[MSTATUS_MIE_BIT]    = trap_csr_rdata_i[MSTATUS_MPIE_BIT];
    stat_ret_s[MSTATUS_MPIE_BIT]   = 1'b1;
  end

  assign jump_base_s = {trap_csr_rdata_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode offsets interrupts only; cause_r MSB marks an interrupt.
  always_comb begin
    if ((trap_csr_rdata_i[1:0] == 2'b01) && cause_r[XLEN-1]) begin
      trap_target_s = jump_base_s + {{(XLEN-6){1'b0}}, cause_r[3:0], 2'b00};
    end else begin
      trap_target_s = jump_base_s;
    end
  end
`else
  assign trap_target_s = jump_base_s;
`endif

  // State register and capture of pc/cause/tval at trap acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      pc_r    <= {XLEN{1'b0}};
      cause_r <= {XLEN{1'b0}};
      tval_r  <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s && !req_is_mret_s) begin
        pc_r    <= pc_i;
        cause_r <= {req_is_irq_s, {(XLEN-5){1'b0}}, req_code_s};
        tval_r  <= req_is_irq_s ? {XLEN{1'b0}} : exc_tval_i;
      end else begin
        pc_r    <= pc_r;
        cause_r <= cause_r;
        tval_r  <= tval_r;
      end
    end
  end

  // Next state and per-state CSR access / redirect decode.
  always_comb begin
    state_nxt_s      = state_r;
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = {CSR_AW{1'b0}};
    trap_csr_wdata_o = {XLEN{1'b0}};
    jump_o           = 1'b0;
    jump_addr_o      = {XLEN{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = req_is_mret_s ? S_RSTAT : S_EPC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EPC: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_AW'(CSR_MEPC);
        trap_csr_wdata_o = pc_r;
        state_nxt_s      = S_CAUSE;
      end
      S_CAUSE: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_AW'(CSR_MCAUSE);
        trap_csr_wdata_o = cause_r;
        state_nxt_s      = S_TVAL;
      end
      S_TVAL: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_AW'(CSR_MTVAL);
        trap_csr_wdata_o = tval_r;
        state_nxt_s      = S_STAT;
      end
      S_STAT: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        trap_csr_wdata_o = stat_entry_s;
        state_nxt_s      = S_JMP;
      end
      S_JMP: begin
        trap_csr_addr_o = CSR_AW'(CSR_MTVEC);
        jump_o          = 1'b1;
        jump_addr_o     = trap_target_s;
        state_nxt_s     = S_IDLE;
      end
      S_RSTAT: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        trap_csr_wdata_o = stat_ret_s;
        state_nxt_s      = S_RJMP;
      end
      S_RJMP: begin
        trap_csr_addr_o = CSR_AW'(CSR_MEPC);
        jump_o          = 1'b1;
        jump_addr_o     = jump_base_s;
        state_nxt_s     = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

endmodule
